// File: rtl/in_port.sv
// Input port: three independent two-entry ping-pong buffers that sit between
// an upstream sender (ccm side) and a reading core. Writes are flow-controlled
// through busy, and reads return each buffer's words in arrival order.
module in_port #(
  parameter int DATA_W = 32
) (
  input  logic              gclock,
  input  logic              reset,
  input  logic [1:0]        i_addr,
  input  logic [DATA_W:0]   data_in,
  output logic              busy,
  input  logic [1:0]        c_addr,
  input  logic              c_read,
  output logic [DATA_W-1:0] c_data,
  output logic              c_data_valid,
  output logic              rd_err,
  output logic [2:0]        data_ready
);

  localparam int unsigned NBUF = 3;

  // Per-buffer storage: two payload slots, one valid bit per slot,
  // and write/read select bits that toggle to alternate between the slots.
  logic [DATA_W-1:0] mem_q [NBUF][2];
  logic [1:0]        vld_q [NBUF];
  logic [1:0]        vld_d [NBUF];
  logic [NBUF-1:0]   wsel_q, wsel_d;
  logic [NBUF-1:0]   rsel_q, rsel_d;
  logic [NBUF-1:0]   full;
  logic [NBUF-1:0]   wr_en;

  logic [DATA_W-1:0] c_data_q, c_data_d;
  logic              c_valid_q, c_valid_d;
  logic              rd_err_q, rd_err_d;
  logic [2:0]        ready_q, ready_d;

  // Flow control comes from pre-edge occupancy only; held low during reset.
  always_comb begin
    full = '0;
    busy = 1'b0;
    for (int unsigned k = 0; k < NBUF; k++) begin
      full[k] = &vld_q[k];
      if (i_addr == 2'(k) && full[k]) busy = 1'b1;
    end
    if (reset) busy = 1'b0;
  end

  // Next-state for valid bits, selects and read outputs. When a write and a
  // read hit the same legal buffer they always touch different slots, since a
  // non-full, non-empty buffer holds exactly one word: wsel points at the
  // empty slot and rsel at the occupied one.
  always_comb begin
    vld_d     = vld_q;
    wsel_d    = wsel_q;
    rsel_d    = rsel_q;
    wr_en     = '0;
    c_data_d  = c_data_q;
    c_valid_d = 1'b0;
    rd_err_d  = 1'b0;
    ready_d   = '0;
    for (int unsigned k = 0; k < NBUF; k++) begin
      if (i_addr == 2'(k) && data_in[DATA_W] && !full[k]) begin
        vld_d[k][wsel_q[k]] = 1'b1;
        wsel_d[k]           = ~wsel_q[k];
        wr_en[k]            = 1'b1;
      end
      if (c_read && c_addr == 2'(k)) begin
        if (vld_q[k][rsel_q[k]]) begin
          c_data_d            = mem_q[k][rsel_q[k]];
          vld_d[k][rsel_q[k]] = 1'b0;
          rsel_d[k]           = ~rsel_q[k];
          c_valid_d           = 1'b1;
        end else begin
          rd_err_d = 1'b1;
        end
      end
      ready_d[k] = |vld_d[k];
    end
  end

  // Control state and registered outputs; reset discards everything in flight.
  always_ff @(posedge gclock) begin
    if (reset) begin
      for (int unsigned k = 0; k < NBUF; k++) vld_q[k] <= '0;
      wsel_q    <= '0;
      rsel_q    <= '0;
      c_data_q  <= '0;
      c_valid_q <= 1'b0;
      rd_err_q  <= 1'b0;
      ready_q   <= '0;
    end else begin
      for (int unsigned k = 0; k < NBUF; k++) vld_q[k] <= vld_d[k];
      wsel_q    <= wsel_d;
      rsel_q    <= rsel_d;
      c_data_q  <= c_data_d;
      c_valid_q <= c_valid_d;
      rd_err_q  <= rd_err_d;
      ready_q   <= ready_d;
    end
  end

  // Payload slots carry no reset; their contents are qualified by the valid bits.
  always_ff @(posedge gclock) begin
    for (int unsigned k = 0; k < NBUF; k++) begin
      if (wr_en[k] && !reset) mem_q[k][wsel_q[k]] <= data_in[DATA_W-1:0];
    end
  end

  assign c_data       = c_data_q;
  assign c_data_valid = c_valid_q;
  assign rd_err       = rd_err_q;
  assign data_ready   = ready_q;

endmodule

// File: tb/tb_in_port.sv
// Bench for in_port: directed scenarios plus randomized traffic, all checked
// against a queue-per-buffer reference model.
module tb_in_port;

  logic        gclock = 1'b0;
  logic        reset;
  logic [1:0]  i_addr;
  logic [32:0] data_in;
  logic        busy;
  logic [1:0]  c_addr;
  logic        c_read;
  logic [31:0] c_data;
  logic        c_data_valid;
  logic        rd_err;
  logic [2:0]  data_ready;

  in_port #(.DATA_W(32)) dut (
    .gclock       (gclock),
    .reset        (reset),
    .i_addr       (i_addr),
    .data_in      (data_in),
    .busy         (busy),
    .c_addr       (c_addr),
    .c_read       (c_read),
    .c_data       (c_data),
    .c_data_valid (c_data_valid),
    .rd_err       (rd_err),
    .data_ready   (data_ready)
  );

  always #5 gclock = ~gclock;

  // Reference model: each buffer is a FIFO of at most two words.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [31:0] exp_cdata = '0;
  logic        exp_cv    = 1'b0;
  logic        exp_re    = 1'b0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned qsize(input logic [1:0] b);
    case (b)
      2'd0:    return q0.size();
      2'd1:    return q1.size();
      2'd2:    return q2.size();
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] exp_ready();
    return {q2.size() > 0, q1.size() > 0, q0.size() > 0};
  endfunction

  // One clock cycle: drive inputs, check busy before the edge, advance the
  // model and check registered outputs after the edge.
  task automatic cyc(input logic [1:0] ia, input logic v, input logic [31:0] pl,
                     input logic [1:0] ca, input logic rd, input logic rs);
    logic eb;
    logic do_wr, do_rd, do_err;
    logic [31:0] word;
    @(negedge gclock);
    i_addr  = ia;
    data_in = {v, pl};
    c_addr  = ca;
    c_read  = rd;
    reset   = rs;
    #1;
    eb = !rs && ia != 2'b11 && qsize(ia) == 2;
    check("busy", {63'd0, busy}, {63'd0, eb});
    do_wr  = !rs && v && ia != 2'b11 && qsize(ia) < 2;
    do_rd  = !rs && rd && ca != 2'b11 && qsize(ca) > 0;
    do_err = !rs && rd && ca != 2'b11 && qsize(ca) == 0;
    @(posedge gclock);
    #1;
    if (rs) begin
      q0.delete(); q1.delete(); q2.delete();
      exp_cdata = '0; exp_cv = 1'b0; exp_re = 1'b0;
    end else begin
      exp_cv = do_rd;
      exp_re = do_err;
      if (do_rd) begin
        case (ca)
          2'd0:    word = q0.pop_front();
          2'd1:    word = q1.pop_front();
          default: word = q2.pop_front();
        endcase
        exp_cdata = word;
      end
      if (do_wr) begin
        case (ia)
          2'd0:    q0.push_back(pl);
          2'd1:    q1.push_back(pl);
          default: q2.push_back(pl);
        endcase
      end
    end
    check("c_data",       {32'd0, c_data},        {32'd0, exp_cdata});
    check("c_data_valid", {63'd0, c_data_valid},  {63'd0, exp_cv});
    check("rd_err",       {63'd0, rd_err},        {63'd0, exp_re});
    check("data_ready",   {61'd0, data_ready},    {61'd0, exp_ready()});
  endtask

  task automatic idle();
    cyc(2'b11, 1'b0, 32'h0, 2'b11, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; i_addr = 2'b11; data_in = '0; c_addr = 2'b11; c_read = 1'b0;
    cyc(2'b11, 1'b0, 32'h0, 2'b11, 1'b0, 1'b1);
    cyc(2'b11, 1'b0, 32'h0, 2'b11, 1'b0, 1'b1);
    check("rst_ready", {61'd0, data_ready}, 64'd0);
    check("rst_cdata", {32'd0, c_data}, 64'd0);

    // Single word round trip through buffer 0.
    cyc(2'd0, 1'b1, 32'hA5A5_0001, 2'b11, 1'b0, 1'b0);
    check("w1_ready", {61'd0, data_ready}, 64'b001);
    cyc(2'b11, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
    check("r1_data",  {32'd0, c_data}, 64'hA5A5_0001);
    check("r1_valid", {63'd0, c_data_valid}, 64'd1);
    check("r1_ready", {61'd0, data_ready}, 64'd0);

    // Third back-to-back write to buffer 2 is dropped.
    cyc(2'd2, 1'b1, 32'h1, 2'b11, 1'b0, 1'b0);
    cyc(2'd2, 1'b1, 32'h2, 2'b11, 1'b0, 1'b0);
    @(negedge gclock);
    cyc(2'd2, 1'b1, 32'h3, 2'b11, 1'b0, 1'b0);
    cyc(2'b11, 1'b0, 32'h0, 2'd2, 1'b1, 1'b0);
    check("b2_first", {32'd0, c_data}, 64'h1);
    cyc(2'b11, 1'b0, 32'h0, 2'd2, 1'b1, 1'b0);
    check("b2_second", {32'd0, c_data}, 64'h2);
    cyc(2'b11, 1'b0, 32'h0, 2'd2, 1'b1, 1'b0);
    check("b2_empty_err", {63'd0, rd_err}, 64'd1);

    // Full buffer 1: concurrent read and write, write refused.
    cyc(2'd1, 1'b1, 32'h5, 2'b11, 1'b0, 1'b0);
    cyc(2'd1, 1'b1, 32'h6, 2'b11, 1'b0, 1'b0);
    cyc(2'd1, 1'b1, 32'h9, 2'd1, 1'b1, 1'b0);
    check("b1_oldest", {32'd0, c_data}, 64'h5);
    check("b1_ready",  {61'd0, data_ready}, 64'b010);
    cyc(2'b11, 1'b0, 32'h0, 2'd1, 1'b1, 1'b0);
    check("b1_next", {32'd0, c_data}, 64'h6);
    cyc(2'b11, 1'b0, 32'h0, 2'd1, 1'b1, 1'b0);
    check("b1_refused", {63'd0, rd_err}, 64'd1);

    // Empty buffer 0: concurrent read and write, read refused, word stored.
    cyc(2'd0, 1'b1, 32'h7, 2'd0, 1'b1, 1'b0);
    check("b0_err",   {63'd0, rd_err}, 64'd1);
    check("b0_hold",  {32'd0, c_data}, 64'h6);
    check("b0_ready", {61'd0, data_ready}, 64'b001);
    cyc(2'b11, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
    check("b0_word", {32'd0, c_data}, 64'h7);

    // Reset in the middle of traffic.
    cyc(2'd0, 1'b1, 32'h11, 2'b11, 1'b0, 1'b0);
    cyc(2'd2, 1'b1, 32'h22, 2'b11, 1'b0, 1'b0);
    cyc(2'd0, 1'b1, 32'h33, 2'd2, 1'b1, 1'b1);
    check("mid_rst_ready", {61'd0, data_ready}, 64'd0);
    check("mid_rst_cdata", {32'd0, c_data}, 64'd0);
    cyc(2'd0, 1'b1, 32'h44, 2'b11, 1'b0, 1'b0);
    cyc(2'b11, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
    check("post_rst_word", {32'd0, c_data}, 64'h44);

    // Ignored writes: flag low or no-transfer address.
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) cyc(2'($urandom_range(0, 2)), 1'b0, $urandom, 2'b11, 1'b0, 1'b0);
      else            cyc(2'b11, 1'b1, $urandom, 2'b11, 1'b0, 1'b0);
      check("ign_ready", {61'd0, data_ready}, 64'd0);
    end
    cyc(2'b11, 1'b0, 32'h0, 2'b11, 1'b1, 1'b0);
    check("none_read_err", {63'd0, rd_err}, 64'd0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 800; i++) begin
      cyc(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), $urandom,
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 79) == 0));
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/in_port.md
IN_PORT -- requirements
Module: in_port

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width of one transfer word.
REQ-002 SHALL have port gclock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising gclock.
REQ-004 SHALL have port i_addr  input  2  buffer addressed by ccm for incoming word; 2'b11 = no transfer.
REQ-005 SHALL have port data_in  input  DATA_W+1  bit DATA_W = valid flag, bits DATA_W-1:0 = payload.
REQ-006 SHALL have port busy  output  1  flow control to upstream sender; 1 = word not accepted this cycle.
REQ-007 SHALL have port c_addr  input  2  buffer addressed by core for reading; 2'b11 = none.
REQ-008 SHALL have port c_read  input  1  core read strobe, one word consumed per high cycle.
REQ-009 SHALL have port c_data  output  DATA_W  registered read data to core.
REQ-010 SHALL have port c_data_valid  output  1  one-cycle pulse: c_data updated by an accepted read.
REQ-011 SHALL have port rd_err  output  1  one-cycle pulse: read of an empty buffer.
REQ-012 SHALL have port data_ready  output  3  per-buffer flag, bit k = buffer k holds at least one word.

Function
REQ-013 SHALL hold three buffers (0..2), each a two-entry ping-pong pair: two payload registers, two valid bits, one write-select bit, one read-select bit.
REQ-014 SHALL drive busy combinationally = (i_addr != 2'b11) and both entries of buffer i_addr valid; busy SHALL use pre-edge state only.
REQ-015 SHALL accept a word on a rising edge when i_addr != 2'b11, data_in[DATA_W] = 1 and busy = 0.
REQ-016 On accept: payload SHALL be written to entry [i_addr][write-select], that valid bit set, write-select toggled.
REQ-017 SHALL ignore data_in when data_in[DATA_W] = 0, i_addr = 2'b11 or busy = 1; no state change.
REQ-018 SHALL accept a read on a rising edge when c_read = 1, c_addr != 2'b11 and entry [c_addr][read-select] valid.
REQ-019 On accepted read: c_data SHALL load that payload, the valid bit SHALL clear, read-select SHALL toggle, c_data_valid SHALL be 1 next cycle; latency c_read to c_data = 1 cycle.
REQ-020 On c_read = 1 with c_addr != 2'b11 and buffer empty: rd_err SHALL pulse 1 next cycle; c_data SHALL hold; c_data_valid SHALL be 0.
REQ-021 On c_read = 1 with c_addr = 2'b11: no effect, no rd_err.
REQ-022 Reads SHALL return words of one buffer in arrival order (FIFO depth 2 per buffer); buffers are independent.
REQ-023 Simultaneous write and read to the same buffer SHALL both take effect in the same edge when each is individually legal per pre-edge state; occupancy then unchanged.
REQ-024 Full buffer with simultaneous read: the write SHALL still be refused (busy = 1 pre-edge); sender retries.
REQ-025 Empty buffer with simultaneous write: the read SHALL be refused with rd_err; the word SHALL be stored.
REQ-026 data_ready SHALL be registered and reflect post-edge occupancy of each buffer.
REQ-027 Select bits SHALL wrap 1 -> 0 by toggling; no overflow or underflow of occupancy is possible.

Reset
REQ-028 With reset = 1 at a rising edge: all valid bits, write-selects, read-selects, c_data, c_data_valid, rd_err, data_ready SHALL become 0.
REQ-029 Reset SHALL override any concurrent transfer or read in that cycle; in-flight words are discarded.
REQ-030 While reset = 1, busy SHALL equal 0 (all buffers empty after first reset edge).

Verification
REQ-031 After reset: i_addr=0, data_in={1,32'hA5A5_0001} one cycle -> data_ready=3'b001; c_read with c_addr=0 -> next cycle c_data=32'hA5A5_0001, c_data_valid=1, data_ready=3'b000.
REQ-032 Write 32'h1, 32'h2, 32'h3 to buffer 2 back-to-back -> busy=1 in third cycle, third word dropped; two reads return 1 then 2.
REQ-033 Buffer 1 full, same cycle c_read on 1 and write of 32'h9 -> read returns oldest word, write refused (busy=1), occupancy 1.
REQ-034 c_read on empty buffer 0 with concurrent write of 32'h7 -> rd_err=1 next cycle, c_data unchanged, data_ready[0]=1; next read returns 32'h7.
REQ-035 Fill buffers 0 and 2, assert reset mid-transfer -> next cycle data_ready=0, c_data=0, busy=0; subsequent first write lands in entry 0.
REQ-036 data_in valid flag 0 or i_addr=2'b11 with random payload for 10 cycles -> no change to data_ready, busy=0.
